// File: rtl/dot_product_sequencer.sv
// Dot-product control FSM: streams A/B operand memories through a shared read
// port, multiply-accumulates the returned words and offers the sum on valid/ready.
module dot_product_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ACC_WIDTH  = 69
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUTPUT} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH:0]     len, len_nxt;
  logic [ADDR_WIDTH:0]     count, count_nxt;
  logic [ACC_WIDTH-1:0]    acc, acc_nxt, acc_sum;
  logic                    rd_en_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic                    busy_nxt, rd_en_nxt, res_valid_nxt, done_nxt;
  logic [ADDR_WIDTH-1:0]   rd_addr_nxt;
  logic [ACC_WIDTH-1:0]    res_data_nxt;

  assign prod = $signed(a_data) * $signed(b_data);

  always_comb begin
    acc_sum = acc;
    if (rd_en_d)
      acc_sum = acc + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  end

  // count holds the number of reads already issued, so the next address is count
  always_comb begin
    state_nxt     = state;
    len_nxt       = len;
    count_nxt     = count;
    acc_nxt       = acc_sum;
    rd_en_nxt     = 1'b0;
    rd_addr_nxt   = rd_addr;
    res_valid_nxt = res_valid;
    res_data_nxt  = res_data;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt = '0;
          if (length != '0) begin
            len_nxt     = length;
            count_nxt   = (ADDR_WIDTH+1)'(1);
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = '0;
            state_nxt   = READ;
          end else begin
            res_valid_nxt = 1'b1;
            res_data_nxt  = '0;
            state_nxt     = OUTPUT;
          end
        end
      end
      READ: begin
        if (count == len) begin
          state_nxt = DRAIN;
        end else begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = count[ADDR_WIDTH-1:0];
          count_nxt   = count + 1'b1;
        end
      end
      DRAIN: begin
        res_valid_nxt = 1'b1;
        res_data_nxt  = acc_sum;
        state_nxt     = OUTPUT;
      end
      OUTPUT: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      count     <= '0;
      acc       <= '0;
      rd_en_d   <= 1'b0;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      count     <= count_nxt;
      acc       <= acc_nxt;
      rd_en_d   <= rd_en;
      busy      <= busy_nxt;
      rd_en     <= rd_en_nxt;
      rd_addr   <= rd_addr_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_data_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: directed vector table,
// hand-written corner sequences and randomized commands against a sum model.
module tb_dot_product_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  length;
  logic        busy;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] a_data = '0;
  logic [31:0] b_data = '0;
  logic        res_valid;
  logic        res_ready;
  logic [68:0] res_data;
  logic        done;

  dot_product_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ACC_WIDTH(69)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int c0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];

  always @(posedge clk)
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end

  typedef struct { int cyc; int addr; } rd_t;
  rd_t rd_log[$];

  always @(negedge clk)
    if (rst_n && rd_en) begin
      rd_t r;
      r.cyc  = cyc - c0;
      r.addr = int'(rd_addr);
      rd_log.push_back(r);
    end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [68:0] got, input logic [68:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [68:0] model_dot(input int n);
    logic signed [68:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s += $signed(mem_a[i]) * $signed(mem_b[i]);
    return s;
  endfunction

  // Issue one command in the current cycle; returns in the cycle done is high.
  task automatic run_cmd(input int n, input int stall, input logic signed [68:0] exp,
                         input int pulse_at);
    int t;
    bit seen;
    rd_log.delete();
    res_ready = (stall == 0);
    start  = 1'b1;
    length = 6'(n);
    c0     = cyc;
    tick();
    start  = 1'b0;
    length = 6'($urandom);
    t = 1;
    check("busy_after_start", busy, 1);
    seen = 0;
    while (!seen && t < n + 20) begin
      if (res_valid) seen = 1;
      else begin
        if (t == pulse_at) begin
          start  = 1'b1;
          length = 6'd3;
        end
        tick();
        start = 1'b0;
        t++;
      end
    end
    check("valid_timeout", seen, 1);
    if (!seen) return;
    check("valid_latency", t, (n == 0) ? 1 : n + 2);
    check("res_data", res_data, exp);
    check("read_count", rd_log.size(), n);
    foreach (rd_log[i]) begin
      check("read_addr", rd_log[i].addr, i % 32);
      check("read_cycle", rd_log[i].cyc, i + 1);
    end
    repeat (stall) begin
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, exp);
      check("no_early_done", done, 0);
    end
    res_ready = 1'b1;
    tick();
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("valid_dropped", res_valid, 0);
  endtask

  typedef struct {
    int                 n;
    int                 stall;
    logic [3:0][31:0]   a;
    logic [3:0][31:0]   b;
    logic signed [68:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bad;
    vecs[0] = '{4, 0, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 69'sd70};
    vecs[1] = '{2, 0, {32'd0, 32'd0, 32'h7FFFFFFF, 32'hFFFFFFFD},
                {32'd0, 32'd0, 32'h7FFFFFFF, 32'd4}, 69'sh3FFFFFFEFFFFFFF5};
    vecs[2] = '{1, 5, {32'd0, 32'd0, 32'd0, 32'd9}, {32'd0, 32'd0, 32'd0, 32'd9}, 69'sd81};
    vecs[3] = '{0, 0, '0, '0, 69'sd0};
    vecs[4] = '{1, 0, {32'd0, 32'd0, 32'd0, 32'hFFFFFFFE}, {32'd0, 32'd0, 32'd0, 32'd3}, -69'sd6};
    vecs[5] = '{3, 2, {32'd0, 32'h80000000, 32'h80000000, 32'h80000000},
                {32'd0, 32'h80000000, 32'h80000000, 32'h80000000}, 69'shC000000000000000};

    rst_n = 1'b0; start = 1'b0; length = '0; res_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[v]) begin
      for (int i = 0; i < 4; i++) begin
        mem_a[i] = vecs[v].a[i];
        mem_b[i] = vecs[v].b[i];
      end
      run_cmd(vecs[v].n, vecs[v].stall, vecs[v].exp, -1);
      tick();
      check("done_one_cycle", done, 0);
    end

    // Full-length vector of -1 words.
    for (int i = 0; i < 32; i++) begin mem_a[i] = '1; mem_b[i] = '1; end
    run_cmd(32, 0, 69'sd32, -1);
    tick();

    // start pulsed during READ is ignored.
    for (int i = 0; i < 32; i++) begin mem_a[i] = $urandom; mem_b[i] = $urandom; end
    run_cmd(8, 0, model_dot(8), 3);
    tick();

    // Back-to-back: second start in the done cycle.
    run_cmd(4, 0, model_dot(4), -1);
    run_cmd(5, 1, model_dot(5), -1);
    tick();
    check("b2b_done_one_cycle", done, 0);

    // Reset in the middle of an 8-element command.
    res_ready = 1'b1;
    start = 1'b1; length = 6'd8;
    tick();
    start = 1'b0;
    bad = 0;
    while (!(rd_en && rd_addr == 5'd2) && bad < 10) begin tick(); bad++; end
    check("reach_addr2", rd_addr, 2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_done", done, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (15) begin
      tick();
      if (res_valid || done || busy) bad++;
    end
    check("no_stale_result", bad, 0);
    run_cmd(6, 1, model_dot(6), -1);
    tick();

    // Randomized commands against the sum model.
    for (int k = 0; k < 20; k++) begin
      int n;
      n = $urandom_range(0, 32);
      for (int i = 0; i < 32; i++) begin
        case ($urandom_range(0, 3))
          0:       mem_a[i] = 32'h80000000;
          1:       mem_a[i] = 32'h7FFFFFFF;
          default: mem_a[i] = $urandom;
        endcase
        mem_b[i] = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      end
      run_cmd(n, $urandom_range(0, 3), model_dot(n), $urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
